// File: rtl/share_recombine_endian.sv
// share_recombine_endian
//   Recombines a Boolean-masked bus of D shares into its unmasked value by
//   XOR, optionally reverses the order of its WIDTH-bit words, and presents
//   the result through one registered valid/ready output stage.
//
//   Build option: define ENDIAN_REVERSE_EN to enable the word reversal.
//   Without it the recombined value passes through in its original order.
//
// Parameters
//   D      number of shares (>= 1)
//   COUNT  bits per share (positive multiple of WIDTH)
//   WIDTH  word size used for the order reversal
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_shares holds a valid transfer
//   in_ready   block accepts a transfer this cycle (= !out_valid | out_ready)
//   in_shares  share i at [i*COUNT +: COUNT], share 0 in the LSBs
//   out_valid  out_data holds a valid result
//   out_ready  consumer accepts out_data this cycle
//   out_data   recombined (and optionally word-reversed) value
module share_recombine_endian #(
  parameter int D     = 2,
  parameter int COUNT = 128,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COUNT*D-1:0] in_shares,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT-1:0]   out_data
);

  localparam int N = COUNT / WIDTH;

  generate
    if ((N * WIDTH) != COUNT || D < 1 || N < 1) begin : g_bad_cfg
      $error("share_recombine_endian: COUNT must be a positive multiple of WIDTH and D >= 1");
    end
  endgenerate

  logic [COUNT-1:0] rec;
  logic [COUNT-1:0] res;
  logic             in_xfer;
  logic             out_valid_q, out_valid_d;
  logic [COUNT-1:0] out_data_q,  out_data_d;

  // Unmask: XOR of all shares.
  always_comb begin
    rec = '0;
    for (int i = 0; i < D; i++) rec = rec ^ in_shares[i*COUNT +: COUNT];
  end

`ifdef ENDIAN_REVERSE_EN
  // Word k of the result takes word N-1-k; bits inside a word keep order.
  for (genvar k = 0; k < N; k++) begin : g_word
    assign res[k*WIDTH +: WIDTH] = rec[(N-1-k)*WIDTH +: WIDTH];
  end
`else
  assign res = rec;
`endif

  // Only combinational output path: out_ready -> in_ready.
  assign in_ready = ~out_valid_q | out_ready;
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_xfer) begin
      // Covers the simultaneous drain+load case: valid stays high.
      out_valid_d = 1'b1;
      out_data_d  = res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_share_recombine_endian.sv
module tb_share_recombine_endian;
  localparam int CA = 128, DA = 2, CB = 32, DB = 3, W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             a_iv, a_ir, a_ov, a_or;
  logic [CA*DA-1:0] a_sh;
  logic [CA-1:0]    a_od;
  logic             b_iv, b_ir, b_ov, b_or;
  logic [CB*DB-1:0] b_sh;
  logic [CB-1:0]    b_od;

  share_recombine_endian #(.D(DA), .COUNT(CA), .WIDTH(W)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_shares(a_sh),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od));

  share_recombine_endian #(.D(DB), .COUNT(CB), .WIDTH(W)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_shares(b_sh),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od));

  int n_chk  = 0;
  int n_fail = 0;
  int a_outs = 0;
  logic [CA-1:0] qa[$];
  logic [CB-1:0] qb[$];

  // Reference: XOR shares, then reverse words when the reversal build is used.
  function automatic logic [CA-1:0] model_a(input logic [CA*DA-1:0] s);
    logic [CA-1:0] rec, r;
    rec = s[CA-1:0] ^ s[2*CA-1:CA];
    r = rec;
`ifdef ENDIAN_REVERSE_EN
    for (int k = 0; k < CA/W; k++) r[k*W +: W] = rec[(CA/W-1-k)*W +: W];
`endif
    return r;
  endfunction

  function automatic logic [CB-1:0] model_b(input logic [CB*DB-1:0] s);
    logic [CB-1:0] rec, r;
    rec = s[CB-1:0] ^ s[2*CB-1:CB] ^ s[3*CB-1:2*CB];
    r = rec;
`ifdef ENDIAN_REVERSE_EN
    for (int k = 0; k < CB/W; k++) r[k*W +: W] = rec[(CB/W-1-k)*W +: W];
`endif
    return r;
  endfunction

  // Scoreboard: at the negedge the handshake inputs/outputs are stable for
  // the coming edge. Pop (output side) before push (input side).
  always @(negedge clk) begin
    logic [CA-1:0] ea;
    logic [CB-1:0] eb;
    if (rst === 1'b0) begin
      if (a_ov && a_or) begin
        n_chk++;
        a_outs++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_unexpected: got %h, expected no output", a_od);
        end else begin
          ea = qa.pop_front();
          if (a_od !== ea) begin
            n_fail++;
            $display("FAIL sb_a_data: got %h, expected %h", a_od, ea);
          end
        end
      end
      if (a_iv && a_ir) qa.push_back(model_a(a_sh));
      if (b_ov && b_or) begin
        n_chk++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_unexpected: got %h, expected no output", b_od);
        end else begin
          eb = qb.pop_front();
          if (b_od !== eb) begin
            n_fail++;
            $display("FAIL sb_b_data: got %h, expected %h", b_od, eb);
          end
        end
      end
      if (b_iv && b_ir) qb.push_back(model_b(b_sh));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_iv = 1'b0; a_or = 1'b0; a_sh = '0;
    b_iv = 1'b0; b_or = 1'b0; b_sh = '0;
    cyc();
    cyc();
    n_chk++;
    if (a_ov !== 1'b0 || a_od !== '0 || a_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: got v=%b d=%h rdy=%b, expected v=0 d=0 rdy=1", a_ov, a_od, a_ir);
    end
    n_chk++;
    if (b_ov !== 1'b0 || b_od !== '0 || b_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_b: got v=%b d=%h rdy=%b, expected v=0 d=0 rdy=1", b_ov, b_od, b_ir);
    end
    rst = 1'b0;
    cyc();
    n_chk++;
    if (a_ov !== 1'b0 || a_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_a: got v=%b rdy=%b, expected v=0 rdy=1", a_ov, a_ir);
    end
  endtask

  // One transfer on DUT A; check result one cycle later, then drain it.
  task automatic send_a(input string name, input logic [CA*DA-1:0] sh, input logic [CA-1:0] exp);
    a_sh = sh; a_iv = 1'b1; a_or = 1'b0;
    cyc();
    a_iv = 1'b0;
    n_chk++;
    if (a_ov !== 1'b1 || a_od !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b d=%h, expected v=1 d=%h", name, a_ov, a_od, exp);
    end
    a_or = 1'b1;
    cyc();
    a_or = 1'b0;
    n_chk++;
    if (a_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got v=%b, expected v=0", name, a_ov);
    end
  endtask

  task automatic test_reversal();
    logic [CA-1:0] exp;
`ifdef ENDIAN_REVERSE_EN
    exp = 128'h0f0e0d0c0b0a09080706050403020100;
`else
    exp = 128'h000102030405060708090a0b0c0d0e0f;
`endif
    send_a("reversal", {128'h0, 128'h000102030405060708090a0b0c0d0e0f}, exp);
  endtask

  task automatic test_recombine();
    send_a("recomb_ff", {{16{8'hFF}}, {16{8'hFF}}}, 128'h0);
    send_a("recomb_a5", {{16{8'h0F}}, {16{8'hA5}}}, {16{8'hAA}});
  endtask

  task automatic send_b(input string name, input logic [CB*DB-1:0] sh, input logic [CB-1:0] exp);
    b_sh = sh; b_iv = 1'b1; b_or = 1'b0;
    cyc();
    b_iv = 1'b0;
    n_chk++;
    if (b_ov !== 1'b1 || b_od !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b d=%h, expected v=1 d=%h", name, b_ov, b_od, exp);
    end
    b_or = 1'b1;
    cyc();
    b_or = 1'b0;
  endtask

  task automatic test_three_shares();
    logic [CB-1:0] exp;
    send_b("d3_cancel", {32'h10203040, 32'h01020304, 32'h11223344}, 32'h0);
`ifdef ENDIAN_REVERSE_EN
    exp = 32'h44332211;
`else
    exp = 32'h11223344;
`endif
    send_b("d3_order", {32'h0, 32'h0, 32'h11223344}, exp);
  endtask

  task automatic test_backpressure();
    logic [CA*DA-1:0] sa, sb;
    sa = {{4{32'hDEADBEEF}}, {4{32'h01234567}}};
    sb = {{4{32'h55AA33CC}}, {4{32'h89ABCDEF}}};
    a_or = 1'b0; a_sh = sa; a_iv = 1'b1;
    cyc();
    a_sh = sb;
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if (a_ov !== 1'b1 || a_od !== model_a(sa) || a_ir !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b, expected v=1 d=%h rdy=0",
                 c, a_ov, a_od, a_ir, model_a(sa));
      end
      cyc();
    end
    a_or = 1'b1;
    #1;
    n_chk++;
    if (a_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_comb: got rdy=%b, expected 1", a_ir);
    end
    cyc();
    a_iv = 1'b0;
    n_chk++;
    if (a_ov !== 1'b1 || a_od !== model_a(sb)) begin
      n_fail++;
      $display("FAIL bp_swap: got v=%b d=%h, expected v=1 d=%h", a_ov, a_od, model_a(sb));
    end
    cyc();
    a_or = 1'b0;
  endtask

  task automatic test_back_to_back();
    int start;
    start = a_outs;
    a_or = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_sh = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      a_iv = 1'b1;
      cyc();
      n_chk++;
      if (a_ov !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_valid%0d: got v=%b, expected 1", i, a_ov);
      end
    end
    a_iv = 1'b0;
    cyc();
    a_or = 1'b0;
    n_chk++;
    if (a_outs - start != 16 || qa.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got %0d outputs (%0d queued), expected 16 (0 queued)",
               a_outs - start, qa.size());
    end
  endtask

  task automatic test_reset_midop();
    a_or = 1'b0; a_iv = 1'b1; a_sh = {8{32'hCAFEF00D}};
    cyc();
    a_sh = {8{32'h12345678}};
    rst = 1'b1;
    cyc();
    rst = 1'b0; a_iv = 1'b0;
    qa.delete();
    n_chk++;
    if (a_ov !== 1'b0 || a_od !== '0 || a_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midop: got v=%b d=%h rdy=%b, expected v=0 d=0 rdy=1", a_ov, a_od, a_ir);
    end
    a_or = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_chk++;
      if (a_ov !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stale%0d: got v=%b, expected 0", c, a_ov);
      end
    end
    a_or = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reversal();
    test_recombine();
    test_three_shares();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    cyc();
    n_chk++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d/%0d queued, expected 0/0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
